// File: rtl/decode_ibuf_if.sv
// Fetch-to-decode bundle for decode_ibuf: push lanes from fetch, issue handshake to decode.
interface decode_ibuf_if #(
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 2
);
    localparam int NUM_W = $clog2(FETCH_W + 1);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  flush;
    logic [NUM_W-1:0]      in_num;
    logic [32*FETCH_W-1:0] in_instr;
    logic [32*FETCH_W-1:0] in_pc;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_instr;
    logic [31:0]           out_pc;
    logic                  out_is_branch;
    logic                  out_in_delay_slot;
    logic [CNT_W-1:0]      count;

    modport master (
        output flush, in_num, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_is_branch,
               out_in_delay_slot, count
    );

    modport slave (
        input  flush, in_num, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_is_branch,
               out_in_delay_slot, count
    );
endinterface

// File: rtl/decode_ibuf.sv
// Instruction queue + pre-decode in front of the decoder; holds a branch until its delay slot is buffered.
// Optional same-cycle bypass into an empty queue: define DECODE_IBUF_BYPASS_EN.
module decode_ibuf #(
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 2
) (
    input  logic         clk,
    input  logic         reset,
    decode_ibuf_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int NUM_W = $clog2(FETCH_W + 1);
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - FETCH_W);

    function automatic logic is_branch(input logic [5:0] opcode, input logic [5:0] funct);
        logic hit;
        hit = 1'b0;
        case (opcode)
            6'b000001, 6'b000010, 6'b000011,
            6'b000100, 6'b000101, 6'b000110, 6'b000111: hit = 1'b1;
            6'b000000: hit = (funct == 6'b001000) || (funct == 6'b001001);
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

    logic [31:0]        instr_mem [DEPTH];
    logic [31:0]        pc_mem    [DEPTH];
    logic               br_mem    [DEPTH];

    logic [PTR_W-1:0]   rptr_reg;
    logic [PTR_W-1:0]   wptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic               ds_pending_reg;

    logic [31:0]        lane_instr [FETCH_W];
    logic [31:0]        lane_pc    [FETCH_W];
    logic [PTR_W-1:0]   lane_addr  [FETCH_W];
    logic [FETCH_W-1:0] lane_br;
    logic [FETCH_W-1:0] lane_we;

    logic               in_ready_c;
    logic               head_br;
    logic               mem_valid;
    logic               push_ok;
    logic               bypass;
    logic               bypass_pop;
    logic               mem_pop;
    logic               issue_br;
    logic [NUM_W-1:0]   stored_num;

    assign head_br    = br_mem[rptr_reg];
    assign in_ready_c = count_reg <= READY_MAX;
    // A branch at the head needs its delay slot already queued behind it.
    assign mem_valid  = (count_reg != '0) && !(head_br && (count_reg < CNT_W'(2)));
    assign push_ok    = in_ready_c && (bus.in_num != '0) && !bus.flush;

`ifdef DECODE_IBUF_BYPASS_EN
    assign bypass = (count_reg == '0) && !bus.flush && (bus.in_num != '0)
                  && (!lane_br[0] || (bus.in_num > NUM_W'(1)));
`else
    assign bypass = 1'b0;
`endif

    // A consumed bypass lane never touches storage; the remaining lanes slide down one slot.
    assign bypass_pop = bypass && bus.out_ready;
    assign mem_pop    = mem_valid && bus.out_ready && !bus.flush;
    assign stored_num = push_ok ? (bus.in_num - NUM_W'(bypass_pop)) : '0;
    assign count_next = count_reg + CNT_W'(stored_num) - CNT_W'(mem_pop);
    assign issue_br   = bypass ? lane_br[0] : head_br;

    generate
        for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_lane
            assign lane_instr[gi] = bus.in_instr[32*gi +: 32];
            assign lane_pc[gi]    = bus.in_pc[32*gi +: 32];
            assign lane_br[gi]    = is_branch(lane_instr[gi][31:26], lane_instr[gi][5:0]);
            assign lane_we[gi]    = push_ok && (NUM_W'(gi) < bus.in_num)
                                  && !((gi == 0) && bypass_pop);
            assign lane_addr[gi]  = wptr_reg + PTR_W'(gi) - PTR_W'(bypass_pop);
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (lane_we[i]) begin
                instr_mem[lane_addr[i]] <= lane_instr[i];
                pc_mem[lane_addr[i]]    <= lane_pc[i];
                br_mem[lane_addr[i]]    <= lane_br[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rptr_reg       <= '0;
            wptr_reg       <= '0;
            count_reg      <= '0;
            ds_pending_reg <= 1'b0;
        end else if (bus.flush) begin
            rptr_reg       <= '0;
            wptr_reg       <= '0;
            count_reg      <= '0;
            ds_pending_reg <= 1'b0;
        end else begin
            wptr_reg  <= wptr_reg + PTR_W'(stored_num);
            rptr_reg  <= rptr_reg + PTR_W'(mem_pop);
            count_reg <= count_next;
            if (mem_pop || bypass_pop) begin
                ds_pending_reg <= issue_br;
            end
        end
    end

    assign bus.in_ready          = in_ready_c;
    assign bus.out_valid         = mem_valid || bypass;
    assign bus.out_instr         = bypass ? lane_instr[0] : instr_mem[rptr_reg];
    assign bus.out_pc            = bypass ? lane_pc[0]    : pc_mem[rptr_reg];
    assign bus.out_is_branch     = issue_br;
    assign bus.out_in_delay_slot = ds_pending_reg;
    assign bus.count             = count_reg;
endmodule

// File: tb/tb_decode_ibuf.sv
// Self-checking bench for decode_ibuf: directed scenarios plus randomized traffic against a queue model.
module tb_decode_ibuf;
    localparam int DEPTH   = 8;
    localparam int FETCH_W = 2;
`ifdef DECODE_IBUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        bit          br;
    } ent_t;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    decode_ibuf_if #(.DEPTH(DEPTH), .FETCH_W(FETCH_W)) bus ();

    decode_ibuf #(.DEPTH(DEPTH), .FETCH_W(FETCH_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_br(input logic [31:0] ins);
        int op;
        int fn;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        return (op == 1) || (op == 2) || (op == 3) || (op >= 4 && op <= 7)
            || (op == 0 && (fn == 8 || fn == 9));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0:       return {6'b000100, r[25:0]};
            1:       return {6'b000010, r[25:0]};
            2:       return {6'b000000, r[25:6], 5'b00100, r[0]};
            3:       return {6'b000000, r[25:0]};
            default: return r;
        endcase
    endfunction

    task automatic drive(input int num, input logic [31:0] i0, input logic [31:0] p0,
                         input logic [31:0] i1, input logic [31:0] p1,
                         input bit fl, input bit rdy);
        bus.in_num    = 2'(num);
        bus.in_instr  = {i1, i0};
        bus.in_pc     = {p1, p0};
        bus.flush     = fl;
        bus.out_ready = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: an ordered queue of entries plus the delay-slot flag.
    ent_t        mq[$];
    bit          m_ds;
    int          m_sz, m_num;
    bit          m_byp, m_vld, m_pop, m_rdy;
    ent_t        m_l0, m_l1, m_h;
    logic [31:0] iss_pc[$];
    bit          iss_ds[$];
    bit          iss_br[$];

    always @(negedge clk) begin
        if (reset) begin
            mq.delete();
            m_ds = 1'b0;
        end else begin
            m_num = int'(bus.in_num);
            m_l0  = '{bus.in_instr[31:0],  bus.in_pc[31:0],  ref_br(bus.in_instr[31:0])};
            m_l1  = '{bus.in_instr[63:32], bus.in_pc[63:32], ref_br(bus.in_instr[63:32])};
            m_sz  = mq.size();
            m_rdy = (DEPTH - m_sz) >= FETCH_W;
            m_byp = BYP && (m_sz == 0) && !bus.flush && (m_num >= 1) && (!m_l0.br || m_num >= 2);
            m_vld = 1'b0;
            if (m_byp) begin
                m_h   = m_l0;
                m_vld = 1'b1;
            end else if (m_sz > 0) begin
                m_h   = mq[0];
                m_vld = !(m_h.br && m_sz < 2);
            end
            chk("out_valid", 32'(bus.out_valid), 32'(m_vld));
            chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
            chk("count", 32'(bus.count), 32'(m_sz));
            chk("delay_slot", 32'(bus.out_in_delay_slot), 32'(m_ds));
            if (m_vld) begin
                chk("out_instr", bus.out_instr, m_h.instr);
                chk("out_pc", bus.out_pc, m_h.pc);
                chk("is_branch", 32'(bus.out_is_branch), 32'(m_h.br));
            end
            if (bus.out_valid && bus.out_ready && !bus.flush) begin
                iss_pc.push_back(bus.out_pc);
                iss_ds.push_back(bus.out_in_delay_slot);
                iss_br.push_back(bus.out_is_branch);
            end
            if (bus.flush) begin
                mq.delete();
                m_ds = 1'b0;
            end else begin
                m_pop = m_vld && bus.out_ready;
                if (m_pop) m_ds = m_h.br;
                if (m_pop && !m_byp) void'(mq.pop_front());
                if (m_rdy && m_num > 0) begin
                    if (!(m_byp && m_pop)) mq.push_back(m_l0);
                    if (m_num >= 2) mq.push_back(m_l1);
                end
            end
        end
    end

    task automatic iss_clear();
        iss_pc.delete();
        iss_ds.delete();
        iss_br.delete();
    endtask

    initial begin
        logic [31:0] pc;
        int          rdy_pct;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 1'b0, 1'b0);
        repeat (2) next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_delay_slot", 32'(bus.out_in_delay_slot), 0);
        chk("rst_count", 32'(bus.count), 0);
        next_cycle();

        // Reset then push two plain instructions
        iss_clear();
        drive(2, 32'h24010001, 32'h1000, 32'h24020002, 32'h1004, 1'b0, 1'b1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1'b0, 1'b1);
        repeat (3) next_cycle();
        @(negedge clk);
        chk("t1_count", 32'(bus.count), 0);
        chk("t1_issued", iss_pc.size(), 2);
        if (iss_pc.size() >= 2) begin
            chk("t1_pc0", iss_pc[0], 32'h1000);
            chk("t1_pc1", iss_pc[1], 32'h1004);
            chk("t1_ds0", 32'(iss_ds[0]), 0);
            chk("t1_ds1", 32'(iss_ds[1]), 0);
        end
        next_cycle();

        // Branch held until its delay slot arrives
        iss_clear();
        drive(1, 32'h10220003, 32'h2000, 0, 0, 1'b0, 1'b1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1'b0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("t2_hold_valid", 32'(bus.out_valid), 0);
            next_cycle();
        end
        drive(1, 32'h00000000, 32'h2004, 0, 0, 1'b0, 1'b1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1'b0, 1'b1);
        repeat (3) next_cycle();
        @(negedge clk);
        chk("t2_issued", iss_pc.size(), 2);
        if (iss_pc.size() >= 2) begin
            chk("t2_pc0", iss_pc[0], 32'h2000);
            chk("t2_br0", 32'(iss_br[0]), 1);
            chk("t2_ds0", 32'(iss_ds[0]), 0);
            chk("t2_pc1", iss_pc[1], 32'h2004);
            chk("t2_br1", 32'(iss_br[1]), 0);
            chk("t2_ds1", 32'(iss_ds[1]), 1);
        end
        next_cycle();

        // Fill to full, drain in order, then stream across the wrap
        iss_clear();
        for (int k = 0; k < 4; k++) begin
            drive(2, 32'h24000000 + 32'(2*k), 32'h3000 + 32'(8*k),
                     32'h24000001 + 32'(2*k), 32'h3004 + 32'(8*k), 1'b0, 1'b0);
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_full_count", 32'(bus.count), 8);
        chk("t3_full_in_ready", 32'(bus.in_ready), 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1'b0, 1'b1);
        repeat (10) next_cycle();
        @(negedge clk);
        chk("t3_drained", iss_pc.size(), 8);
        for (int i = 0; i < 8 && i < iss_pc.size(); i++)
            chk("t3_drain_pc", iss_pc[i], 32'h3000 + 32'(4*i));
        next_cycle();
        iss_clear();
        for (int k = 0; k < 6; k++) begin
            drive(2, 32'h24100000, 32'h3100 + 32'(8*k), 32'h24100001, 32'h3104 + 32'(8*k), 1'b0, 1'b1);
            next_cycle();
            drive(0, 0, 0, 0, 0, 1'b0, 1'b1);
            next_cycle();
        end
        repeat (6) next_cycle();
        @(negedge clk);
        chk("t3_wrap_issued", iss_pc.size(), 12);
        for (int i = 0; i < 12 && i < iss_pc.size(); i++)
            chk("t3_wrap_pc", iss_pc[i], 32'h3100 + 32'(4*i));
        next_cycle();

        // Flush collides with a push while a delay slot is pending
        drive(2, 32'h10220003, 32'h4000, 32'h00000000, 32'h4004, 1'b0, 1'b0);
        next_cycle();
        drive(2, 32'h24000010, 32'h4008, 32'h24000011, 32'h400c, 1'b0, 1'b0);
        next_cycle();
        drive(2, 32'h24000012, 32'h4010, 32'h24000013, 32'h4014, 1'b0, 1'b0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("t4_head_valid", 32'(bus.out_valid), 1);
        chk("t4_head_branch", 32'(bus.out_is_branch), 1);
        chk("t4_head_pc", bus.out_pc, 32'h4000);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_pre_count", 32'(bus.count), 5);
        chk("t4_pre_ds", 32'(bus.out_in_delay_slot), 1);
        next_cycle();
        drive(2, 32'h24000020, 32'h4100, 32'h24000021, 32'h4104, 1'b1, 1'b1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_flush_count", 32'(bus.count), 0);
        chk("t4_flush_valid", 32'(bus.out_valid), 0);
        chk("t4_flush_ds", 32'(bus.out_in_delay_slot), 0);
        next_cycle();

        // Asynchronous reset mid-cycle
        drive(2, 32'h24000030, 32'h4200, 32'h24000031, 32'h4204, 1'b0, 1'b0);
        next_cycle();
        drive(1, 32'h24000032, 32'h4208, 0, 0, 1'b0, 1'b0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1'b0, 1'b0);
        #2;
        chk("t5_pre_valid", 32'(bus.out_valid), 1);
        chk("t5_pre_count", 32'(bus.count), 3);
        reset = 1'b1;
        #1;
        chk("t5_async_valid", 32'(bus.out_valid), 0);
        chk("t5_async_count", 32'(bus.count), 0);
        chk("t5_async_in_ready", 32'(bus.in_ready), 1);
        next_cycle();
        reset = 1'b0;

        // Latency into an empty queue
        drive(1, 32'h24050005, 32'h5000, 0, 0, 1'b0, 1'b1);
`ifdef DECODE_IBUF_BYPASS_EN
        @(negedge clk);
        chk("t6_byp_valid", 32'(bus.out_valid), 1);
        chk("t6_byp_pc", bus.out_pc, 32'h5000);
        chk("t6_byp_instr", bus.out_instr, 32'h24050005);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("t6_byp_count", 32'(bus.count), 0);
`else
        @(negedge clk);
        chk("t6_nobyp_valid", 32'(bus.out_valid), 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_nobyp_count", 32'(bus.count), 1);
        chk("t6_nobyp_valid1", 32'(bus.out_valid), 1);
        chk("t6_nobyp_pc", bus.out_pc, 32'h5000);
`endif
        next_cycle();

        // Randomized traffic checked every cycle by the model
        pc = 32'h8000;
        for (int c = 0; c < 4000; c++) begin
            rdy_pct = ((c / 200) % 2 == 1) ? 90 : 35;
            drive($urandom_range(0, 2), rand_instr(), pc, rand_instr(), pc + 4,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 99) < rdy_pct);
            pc = pc + 8;
            reset = ($urandom_range(0, 599) == 0);
            next_cycle();
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 1'b0, 1'b0);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
